// File: rtl/score_bcd_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : score_bcd_accumulator
// Description : Per-player packed-BCD score register. Line-clear and
//               soft-drop events become BCD addends that are added one digit
//               per cycle. The add repeats once per level (clamped), which
//               gives level scaling without a binary multiplier. A carry out
//               of the top digit clamps the score to all nines.
//               Optional macro NES_SCORING_EN selects the alternative
//               line-clear addend table (40/100/300/1200).
// Revision    : 1.0 - initial release
// ============================================================================
module score_bcd_accumulator #(
    parameter int NUM_DIGITS = 6,
    parameter int MAX_LEVEL  = 9
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    clear_score,
    input  logic                    lines_valid,
    input  logic [2:0]              lines_cleared,
    input  logic [3:0]              level,
    input  logic                    drop_pulse,
    output logic                    ready,
    output logic [4*NUM_DIGITS-1:0] score_digits,
    output logic                    saturated
);

    localparam int c_W     = 4 * NUM_DIGITS;
    localparam int c_IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [c_IDX_W-1:0] c_LAST_IDX  = c_IDX_W'(NUM_DIGITS - 1);
    localparam logic [4:0]         c_MAX_LEVEL = 5'(MAX_LEVEL);
    localparam logic [c_W-1:0]     c_ALL_NINES = {NUM_DIGITS{4'h9}};
    localparam logic [c_W-1:0]     c_DROP_ADD  = c_W'(1);

    // Line-clear addends written as six BCD digits, then resized to the
    // configured score width.
`ifdef NES_SCORING_EN
    localparam logic [23:0] c_BCD_L1 = 24'h000040;
    localparam logic [23:0] c_BCD_L2 = 24'h000100;
    localparam logic [23:0] c_BCD_L3 = 24'h000300;
    localparam logic [23:0] c_BCD_L4 = 24'h001200;
`else
    localparam logic [23:0] c_BCD_L1 = 24'h000100;
    localparam logic [23:0] c_BCD_L2 = 24'h000300;
    localparam logic [23:0] c_BCD_L3 = 24'h000500;
    localparam logic [23:0] c_BCD_L4 = 24'h000800;
`endif

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_ADD  = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_next;
    logic [c_W-1:0]     r_score;
    logic               r_saturated;
    logic [c_W-1:0]     r_work;
    logic [c_W-1:0]     r_addend;
    logic [4:0]         r_pass_cnt;
    logic [c_IDX_W-1:0] r_digit_idx;
    logic               r_carry;

    logic               w_lines_ok;
    logic               w_accept;
    logic [c_W-1:0]     w_lines_addend;
    logic [c_W-1:0]     w_addend;
    logic [4:0]         w_level_clamped;
    logic [4:0]         w_pass_init;
    logic [3:0]         w_work_digit;
    logic [3:0]         w_add_digit;
    logic [4:0]         w_digit_sum;
    logic               w_digit_over;
    logic [3:0]         w_digit_out;
    logic [c_W-1:0]     w_work_next;
    logic               w_last_digit;

    // Event decode, addend selection and the single-digit BCD adder.
    always_comb begin
        w_lines_ok      = lines_valid && (lines_cleared != 3'd0) && (lines_cleared <= 3'd4);
        w_accept        = (r_state == c_ST_IDLE) && (w_lines_ok || drop_pulse);

        case (lines_cleared)
            3'd1:    w_lines_addend = c_W'(c_BCD_L1);
            3'd2:    w_lines_addend = c_W'(c_BCD_L2);
            3'd3:    w_lines_addend = c_W'(c_BCD_L3);
            3'd4:    w_lines_addend = c_W'(c_BCD_L4);
            default: w_lines_addend = '0;
        endcase
        // Lines take precedence; a simultaneous drop is simply discarded.
        w_addend        = w_lines_ok ? w_lines_addend : c_DROP_ADD;

        w_level_clamped = ({1'b0, level} > c_MAX_LEVEL) ? c_MAX_LEVEL : {1'b0, level};
        w_pass_init     = w_lines_ok ? (w_level_clamped + 5'd1) : 5'd1;

        w_work_digit    = r_work[{r_digit_idx, 2'b00} +: 4];
        w_add_digit     = r_addend[{r_digit_idx, 2'b00} +: 4];
        w_digit_sum     = {1'b0, w_work_digit} + {1'b0, w_add_digit} + {4'b0000, r_carry};
        w_digit_over    = (w_digit_sum > 5'd9);
        w_digit_out     = w_digit_over ? 4'(w_digit_sum - 5'd10) : w_digit_sum[3:0];

        w_work_next     = r_work;
        w_work_next[{r_digit_idx, 2'b00} +: 4] = w_digit_out;

        w_last_digit    = (r_digit_idx == c_LAST_IDX);
    end

    // Next-state: leave ADD on the last digit of the final pass or on overflow.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (w_accept) w_state_next = c_ST_ADD;
            c_ST_ADD:  if (w_last_digit && (w_digit_over || (r_pass_cnt == 5'd1)))
                           w_state_next = c_ST_IDLE;
            default:   w_state_next = c_ST_IDLE;
        endcase
    end

    // State register; clear_score has the same effect as Reset.
    always_ff @(posedge Clk) begin
        if (Reset || clear_score) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath: latch the event, ripple one digit per cycle, commit per pass.
    always_ff @(posedge Clk) begin
        if (Reset || clear_score) begin
            r_score     <= '0;
            r_saturated <= 1'b0;
            r_work      <= '0;
            r_addend    <= '0;
            r_pass_cnt  <= 5'd0;
            r_digit_idx <= '0;
            r_carry     <= 1'b0;
        end else if (r_state == c_ST_IDLE) begin
            if (w_accept) begin
                r_addend    <= w_addend;
                r_pass_cnt  <= w_pass_init;
                r_work      <= r_score;
                r_digit_idx <= '0;
                r_carry     <= 1'b0;
            end
        end else if (!w_last_digit) begin
            r_work      <= w_work_next;
            r_carry     <= w_digit_over;
            r_digit_idx <= r_digit_idx + c_IDX_W'(1);
        end else begin
            // Commit edge: the only place the visible score changes.
            r_digit_idx <= '0;
            r_carry     <= 1'b0;
            r_pass_cnt  <= r_pass_cnt - 5'd1;
            if (w_digit_over) begin
                r_score     <= c_ALL_NINES;
                r_work      <= c_ALL_NINES;
                r_saturated <= 1'b1;
            end else begin
                r_score     <= w_work_next;
                r_work      <= w_work_next;
            end
        end
    end

    assign ready        = (r_state == c_ST_IDLE);
    assign score_digits = r_score;
    assign saturated    = r_saturated;

endmodule
`default_nettype wire
